// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for an in-order pipeline: tracks in-flight destinations
// after ID and produces load-use stalls, redirect flushes and forwarding selects.
module pipeline_hazard_ctrl #(
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned RAW        = 5,
    parameter int unsigned LOAD_STAGE = 3,
    parameter int unsigned RED_STAGE  = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [RAW-1:0]             id_rs1,
    input  logic [RAW-1:0]             id_rs2,
    input  logic                       id_rs1_used,
    input  logic                       id_rs2_used,
    input  logic [RAW-1:0]             id_rd,
    input  logic                       id_regWrite,
    input  logic                       id_memRead,
    input  logic                       redirect,
    output logic                       stall,
    output logic                       flush_if_id,
    output logic                       flush_id_ex,
    output logic [$clog2(DEPTH+1)-1:0] fwd_sel1,
    output logic [$clog2(DEPTH+1)-1:0] fwd_sel2,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam int unsigned SW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic           valid;
        logic [RAW-1:0] rd;
        logic           wr;
        logic           ld;
    } entry_t;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic          late;
    } lookup_t;

    entry_t  trk [1:DEPTH];
    entry_t  id_entry;
    lookup_t lk1;
    lookup_t lk2;
    logic    load_id;

    // Only the youngest producer decides both the select and availability,
    // so an older ready copy can never hide a younger pending load.
    function automatic lookup_t youngest(input logic [RAW-1:0] rs,
                                         input logic           used,
                                         input entry_t         t [1:DEPTH]);
        lookup_t r;
        logic    found;
        r     = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            if (!found && used && (rs != '0) && t[k].valid && t[k].wr && (t[k].rd == rs)) begin
                found  = 1'b1;
                r.sel  = SW'(k);
                r.late = t[k].ld && (k < LOAD_STAGE);
            end
        end
        return r;
    endfunction

    always_comb begin
        lk1         = youngest(id_rs1, id_rs1_used, trk);
        lk2         = youngest(id_rs2, id_rs2_used, trk);
        stall       = id_valid && !redirect && (lk1.late || lk2.late);
        flush_if_id = redirect;
        flush_id_ex = redirect || stall;
        fwd_sel1    = lk1.sel;
        fwd_sel2    = lk2.sel;
        load_id     = id_valid && !stall && !redirect;
        id_entry    = '{valid: 1'b1, rd: id_rd, wr: id_regWrite, ld: id_memRead};
    end

    // Stages up to RED_STAGE hold wrong-path work on redirect; older stages,
    // including the redirecting instruction itself, keep advancing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                trk[k] <= '0;
            end
        end else begin
            trk[1] <= load_id ? id_entry : '0;
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                trk[k] <= (redirect && (k <= RED_STAGE)) ? '0 : trk[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a stage-queue model checked every
// cycle, plus hand-computed expectations for the named scenarios.
module tb_pipeline_hazard_ctrl;

    localparam int DEPTH      = 3;
    localparam int RAW        = 5;
    localparam int LOAD_STAGE = 3;
    localparam int RED_STAGE  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           id_valid, id_rs1_used, id_rs2_used, id_regWrite, id_memRead, redirect;
    logic [RAW-1:0] id_rs1, id_rs2, id_rd;

    logic        stall, flush_if_id, flush_id_ex;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall, s_fif, s_fie;
    logic [1:0]  s_sel1, s_sel2;
    logic [3:0]  s_scnt, s_fcnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regWrite(id_regWrite), .id_memRead(id_memRead), .redirect(redirect),
        .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regWrite(id_regWrite), .id_memRead(id_memRead), .redirect(redirect),
        .stall(s_stall), .flush_if_id(s_fif), .flush_id_ex(s_fie),
        .fwd_sel1(s_sel1), .fwd_sel2(s_sel2), .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- model: pipe[i] is the instruction in stage i+1 ----------------
    typedef struct { bit v; int rd; bit wr; bit ld; } ins_t;
    ins_t pipe[$];
    int   m_stalls = 0;
    int   m_flushes = 0;

    function automatic int youngest(input int rs, input bit used);
        for (int k = 1; k <= DEPTH; k++)
            if (pipe[k-1].v && pipe[k-1].wr && pipe[k-1].rd == rs && rs != 0 && used) return k;
        return 0;
    endfunction

    function automatic bit late(input int k);
        if (k == 0) return 1'b0;
        return pipe[k-1].ld && (k < LOAD_STAGE);
    endfunction

    function automatic bit exp_stall();
        return id_valid && !redirect &&
               (late(youngest(int'(id_rs1), id_rs1_used)) || late(youngest(int'(id_rs2), id_rs2_used)));
    endfunction

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    initial begin
        ins_t bub, n;
        bit   s;
        bub = '{v: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
        for (int i = 0; i < DEPTH; i++) pipe.push_back(bub);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                foreach (pipe[i]) pipe[i] = bub;
                m_stalls  = 0;
                m_flushes = 0;
            end else begin
                s = exp_stall();
                if (s) m_stalls++;
                if (redirect) m_flushes++;
                n = (id_valid && !s && !redirect) ?
                    '{v: 1'b1, rd: int'(id_rd), wr: id_regWrite, ld: id_memRead} : bub;
                pipe.push_front(n);
                void'(pipe.pop_back());
                if (redirect) for (int i = 0; i < RED_STAGE; i++) pipe[i] = bub;
            end
        end
    end

    initial begin
        bit es;
        forever begin
            @(negedge clk);
            es = exp_stall();
            chk("m_stall", stall, es);
            chk("m_flush_if_id", flush_if_id, redirect);
            chk("m_flush_id_ex", flush_id_ex, redirect | es);
            if (!es) begin
                chk("m_fwd_sel1", fwd_sel1, youngest(int'(id_rs1), id_rs1_used));
                chk("m_fwd_sel2", fwd_sel2, youngest(int'(id_rs2), id_rs2_used));
            end
            chk("m_stall_cnt", stall_cnt, sat(m_stalls, 16));
            chk("m_flush_cnt", flush_cnt, sat(m_flushes, 16));
            chk("m_stall_cnt4", s_scnt, sat(m_stalls, 4));
            chk("m_flush_cnt4", s_fcnt, sat(m_flushes, 4));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic drv(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit w, input bit ld, input bit rdr);
        id_valid = v;    id_rs1 = RAW'(r1); id_rs1_used = u1; id_rs2 = RAW'(r2); id_rs2_used = u2;
        id_rd = RAW'(rd); id_regWrite = w;  id_memRead = ld;  redirect = rdr;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) nxt();
    endtask

    // Keep the ID instruction in place until the hazard clears, bounded.
    task automatic hold();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!stall) begin
                nxt();
                return;
            end
            nxt();
        end
        chk("hold_timeout", stall, 0);
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_sel1", fwd_sel1, 0);
        chk("rst_sel2", fwd_sel2, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_flush_if_id", flush_if_id, 1);
        chk("rst_flush_id_ex", flush_id_ex, 1);
        nxt();
        nop(0);
        rst = 1'b0;

        // ALU back-to-back: add x5 ; sub x6,x5,x1
        drv(1, 1, 1, 2, 1, 5, 1, 0, 0); nxt();
        drv(1, 5, 1, 1, 1, 6, 1, 0, 0); @(negedge clk);
        chk("alu_b2b_sel1", fwd_sel1, 1);
        chk("alu_b2b_sel2", fwd_sel2, 0);
        chk("alu_b2b_stall", stall, 0);
        nxt(); nop(3);

        // ALU with one independent instruction between
        drv(1, 1, 1, 2, 1, 5, 1, 0, 0); nxt();
        drv(1, 1, 1, 2, 1, 10, 1, 0, 0); nxt();
        drv(1, 5, 1, 1, 1, 6, 1, 0, 0); @(negedge clk);
        chk("alu_gap_sel1", fwd_sel1, 2);
        nxt(); nop(3);

        // Load-use: lw x7 ; add x8,x7,x7
        drv(1, 3, 1, 0, 0, 7, 1, 1, 0); nxt();
        drv(1, 7, 1, 7, 1, 8, 1, 0, 0); @(negedge clk);
        chk("lu_stall_a", stall, 1);
        chk("lu_flush_id_ex_a", flush_id_ex, 1);
        chk("lu_flush_if_id_a", flush_if_id, 0);
        nxt(); @(negedge clk);
        chk("lu_stall_b", stall, 1);
        nxt(); @(negedge clk);
        chk("lu_stall_c", stall, 0);
        chk("lu_sel1", fwd_sel1, 3);
        chk("lu_sel2", fwd_sel2, 3);
        chk("lu_stall_cnt", stall_cnt, 2);
        nxt(); nop(3);

        // Youngest wins: x9 at stages 1 and 3
        drv(1, 1, 1, 2, 1, 9, 1, 0, 0); nxt();
        drv(1, 1, 1, 2, 1, 11, 1, 0, 0); nxt();
        drv(1, 1, 1, 2, 1, 9, 1, 0, 0); nxt();
        drv(1, 9, 1, 9, 1, 12, 1, 0, 0); @(negedge clk);
        chk("young_sel1", fwd_sel1, 1);
        chk("young_sel2", fwd_sel2, 1);
        nxt(); nop(3);

        // x0 guard with a load producer, then unused sources
        drv(1, 3, 1, 0, 0, 0, 1, 1, 0); nxt();
        drv(1, 0, 1, 0, 1, 13, 1, 0, 0); @(negedge clk);
        chk("x0_stall", stall, 0);
        chk("x0_sel1", fwd_sel1, 0);
        nxt();
        drv(1, 3, 1, 0, 0, 7, 1, 1, 0); nxt();
        drv(1, 7, 0, 7, 0, 13, 1, 0, 0); @(negedge clk);
        chk("unused_stall", stall, 0);
        chk("unused_sel2", fwd_sel2, 0);
        nxt(); nop(3);

        // Older ready x7 at stage 3 must not hide the pending load at stage 1
        drv(1, 1, 1, 2, 1, 7, 1, 0, 0); nxt();
        drv(1, 1, 1, 2, 1, 10, 1, 0, 0); nxt();
        drv(1, 3, 1, 0, 0, 7, 1, 1, 0); nxt();
        drv(1, 7, 1, 0, 0, 14, 1, 0, 0); @(negedge clk);
        chk("no_mask_stall", stall, 1);
        hold(); nop(3);

        // Redirect during load-use stall
        drv(1, 3, 1, 0, 0, 7, 1, 1, 0); nxt();
        drv(1, 7, 1, 0, 0, 8, 1, 0, 0); @(negedge clk);
        chk("red_pre_stall", stall, 1);
        nxt();
        redirect = 1'b1; @(negedge clk);
        chk("red_stall", stall, 0);
        chk("red_flush_if_id", flush_if_id, 1);
        chk("red_flush_id_ex", flush_id_ex, 1);
        nxt();
        drv(1, 7, 1, 8, 1, 0, 0, 0, 0); @(negedge clk);
        chk("red_after_sel1", fwd_sel1, 3);
        chk("red_after_sel2", fwd_sel2, 0);
        chk("red_flush_cnt", flush_cnt, 1);
        nxt();
        drv(1, 1, 1, 2, 1, 12, 1, 0, 0); nxt();
        drv(1, 1, 1, 2, 1, 13, 1, 0, 0); nxt();
        drv(1, 1, 1, 2, 1, 10, 1, 0, 1); nxt();
        drv(1, 13, 1, 12, 1, 0, 0, 0, 0); @(negedge clk);
        chk("red2_sel1", fwd_sel1, 0);
        chk("red2_sel2", fwd_sel2, 3);
        chk("red2_flush_cnt", flush_cnt, 2);
        nxt(); nop(3);

        // Saturation: ten load-use pairs, two stall cycles each
        for (int i = 0; i < 10; i++) begin
            drv(1, 3, 1, 0, 0, 7, 1, 1, 0); nxt();
            drv(1, 7, 1, 7, 1, 8, 1, 0, 0); hold();
        end
        nop(0); @(negedge clk);
        chk("sat_stall_cnt4", s_scnt, 15);
        chk("sat_flush_cnt4", s_fcnt, 2);
        chk("sat_stall_cnt16", stall_cnt, 25);
        nxt(); nop(3);

        // Async reset between edges
        drv(1, 1, 1, 2, 1, 14, 1, 0, 0); nxt();
        drv(1, 14, 1, 0, 0, 15, 1, 0, 0); #1;
        chk("arst_pre_sel1", fwd_sel1, 1);
        rst = 1'b1; #1;
        chk("arst_sel1", fwd_sel1, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        chk("arst_flush_cnt", flush_cnt, 0);
        chk("arst_stall_cnt4", s_scnt, 0);
        rst = 1'b0;
        nxt();
        drv(1, 15, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
        chk("post_rst_sel1", fwd_sel1, 1);
        nxt(); nop(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters: DEPTH, default 3, number of tracked stages after ID (1=EX, 2=MEM, 3=WB); legal range 2..7.
REQ-002 Parameters: RAW, default 5, register-address width.
REQ-003 Parameters: LOAD_STAGE, default 3, first stage whose load result is forwardable; legal range 1..DEPTH.
REQ-004 Parameters: RED_STAGE, default 2, stage raising redirect; legal range 1..DEPTH-1.
REQ-005 Parameters: CNT_W, default 16, statistics counter width.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-007 Ports: clk, in, 1, rising-edge clock.
REQ-008 Ports: rst, in, 1, asynchronous active-high reset.
REQ-009 Ports: id_valid, in, 1, ID holds a real instruction.
REQ-010 Ports: id_rs1 / id_rs2, in, RAW each, source register addresses.
REQ-011 Ports: id_rs1_used / id_rs2_used, in, 1 each, source register is actually read.
REQ-012 Ports: id_rd, in, RAW, destination register.
REQ-013 Ports: id_regWrite, in, 1, ID instruction writes rd.
REQ-014 Ports: id_memRead, in, 1, ID instruction is a load.
REQ-015 Ports: redirect, in, 1, taken branch/jump resolved in stage RED_STAGE.
REQ-016 Ports: stall, out, 1, hold PC and IF/ID.
REQ-017 Ports: flush_if_id, out, 1, kill IF/ID contents.
REQ-018 Ports: flush_id_ex, out, 1, write a bubble into ID/EX.
REQ-019 Ports: fwd_sel1 / fwd_sel2, out, clog2(DEPTH+1) each; 0 selects register file, k selects the stage-k result.
REQ-020 Ports: stall_cnt / flush_cnt, out, CNT_W each, statistics.

Function
REQ-021 The block SHALL hold a DEPTH-entry tracker; each entry contains {valid, rd, wr, ld}.
REQ-022 Entry k SHALL describe the instruction currently in stage k.
REQ-023 Every cycle, entry[k] SHALL take entry[k-1] for k>=2; entry[DEPTH] is discarded.
REQ-024 Entry[1] SHALL take the ID fields when id_valid & !stall & !redirect; otherwise it takes a bubble (valid=0).
REQ-025 On redirect, entries 1..RED_STAGE SHALL take bubbles on the next edge.
REQ-026 On redirect, entries above RED_STAGE SHALL shift normally, so the redirecting instruction survives.
REQ-027 Match(rs, k) SHALL require entry[k].valid & entry[k].wr & rd==rs & rs!=0 & rs_used.
REQ-028 fwd_selN SHALL equal the smallest k satisfying Match (youngest producer); it SHALL be 0 if no match.
REQ-029 The youngest match SHALL be unavailable when entry[k].ld & k<LOAD_STAGE.
REQ-030 Older matches SHALL never mask a younger unavailable match.
REQ-031 stall SHALL be id_valid & !redirect & (either source's youngest match unavailable); it is combinational.
REQ-032 flush_if_id SHALL equal redirect.
REQ-033 flush_id_ex SHALL equal redirect | stall.
REQ-034 When stall=1, fwd_sel outputs are don't-care.
REQ-035 When redirect=1, stall SHALL be forced 0; redirect has priority over stall.
REQ-036 stall_cnt SHALL increment on every cycle with stall=1.
REQ-037 flush_cnt SHALL increment on every cycle with redirect=1.
REQ-038 Both counters SHALL saturate at all-ones, without wrap.
REQ-039 There SHALL be no added latency: hazard outputs derive from current tracker state plus current ID inputs.

Reset
REQ-040 While rst=1, all tracker entries SHALL be invalid and stall_cnt=flush_cnt=0.
REQ-041 During reset, stall=0 and fwd_sel1=fwd_sel2=0; flush_if_id and flush_id_ex follow their combinational definitions in REQ-032/REQ-033.
REQ-042 Assertion of rst mid-operation SHALL clear the tracker immediately, without waiting for clk.
REQ-043 The first edge after rst deasserts SHALL load entry[1] normally.

Verification (defaults: DEPTH=3, LOAD_STAGE=3, RED_STAGE=2)
REQ-044 ALU back-to-back: add x5 then sub x6,x5,x1 -> fwd_sel1=1, stall=0.
REQ-045 ALU back-to-back, one cycle later with an independent instruction between: fwd_sel1=2 (same test as REQ-044).
REQ-046 Load-use: lw x7 then add x8,x7,x7 -> stall=1 for two cycles (ld at stage 1, then 2), then fwd_sel1=fwd_sel2=3; stall_cnt=2.
REQ-047 Youngest wins: x9 written at stages 1 and 3, ID reads x9 -> fwd_sel=1.
REQ-048 x0 guard: rd=0 producer, ID reads x0 -> fwd_sel=0, no stall.
REQ-049 Redirect during load-use stall: redirect=1 -> stall=0, flush_if_id=1, flush_id_ex=1; next cycle entries 1,2 invalid, entry 3 valid; flush_cnt=1.
REQ-050 Saturation (CNT_W=4): 20 stall cycles -> stall_cnt=15.
REQ-051 Async reset mid-stream: rst pulsed between edges -> tracker cleared, fwd_sel=0 before the next clk.
